// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the writeback arbiter.
// Contents: XLEN, REG_ADDR_W, NUM_REGS, wb_req_t, wb_src_t.
package wb_arbiter_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    // Source feeding the register file in a given cycle.
    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_ALU,
        SRC_FIFO,
        SRC_MDU
    } wb_src_t;

endpackage

// File: rtl/wb_fifo.sv
// Small FIFO buffering MUL/DIV writeback requests.
// Ports: clk, rst (sync, active-high), push, push_data, pop, head, full, empty.
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  wb_req_t push_data,
    input  logic    pop,
    output wb_req_t head,
    output logic    full,
    output logic    empty
);

    localparam int AW = $clog2(DEPTH);

    wb_req_t       mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges single-cycle ALU results and buffered
// MUL/DIV results into one register-file write port, with a busy
// scoreboard for outstanding MUL/DIV destinations.
// Ports: clk, rst, alu_*, mdu_*, issue_*, busy, reg_write, rd, write_data.
// Optional macro WB_BYPASS_EN adds fwd_valid/fwd_rd/fwd_data.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    input  logic                  mdu_valid,
    output logic                  mdu_ready,
    input  logic [REG_ADDR_W-1:0] mdu_rd,
    input  logic [XLEN-1:0]       mdu_data,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    output logic [NUM_REGS-1:0]   busy,
    output logic                  reg_write,
    output logic [REG_ADDR_W-1:0] rd,
    output logic [XLEN-1:0]       write_data
`ifdef WB_BYPASS_EN
    ,
    output logic                  fwd_valid,
    output logic [REG_ADDR_W-1:0] fwd_rd,
    output logic [XLEN-1:0]       fwd_data
`endif
);

    wb_src_t             sel;
    wb_req_t             sel_req;
    wb_req_t             fifo_head;
    wb_req_t             mdu_req;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_push;
    logic                fifo_pop;
    logic                sel_write;
    logic                mdu_done;
    logic [NUM_REGS-1:0] busy_next;

    assign mdu_req   = '{rd: mdu_rd, data: mdu_data};
    assign mdu_ready = !fifo_full;
    assign alu_ready = !fifo_full;

    // A full FIFO drains first so MUL/DIV can never be starved by ALU.
    // An empty FIFO lets a lone MDU result go straight through.
    always_comb begin
        sel = SRC_NONE;
        if (fifo_full) begin
            sel = SRC_FIFO;
        end else if (alu_valid) begin
            sel = SRC_ALU;
        end else if (!fifo_empty) begin
            sel = SRC_FIFO;
        end else if (mdu_valid) begin
            sel = SRC_MDU;
        end
    end

    always_comb begin
        sel_req = '0;
        unique case (sel)
            SRC_ALU:  sel_req = '{rd: alu_rd, data: alu_data};
            SRC_FIFO: sel_req = fifo_head;
            SRC_MDU:  sel_req = mdu_req;
            default:  sel_req = '0;
        endcase
    end

    assign fifo_push = mdu_valid && !fifo_full && (sel != SRC_MDU);
    assign fifo_pop  = (sel == SRC_FIFO);
    assign sel_write = (sel != SRC_NONE) && (sel_req.rd != '0);
    assign mdu_done  = sel_write && ((sel == SRC_FIFO) || (sel == SRC_MDU));

    // Set after clear so a same-cycle re-issue keeps the bit high.
    always_comb begin
        busy_next = busy;
        if (mdu_done) begin
            busy_next[sel_req.rd] = 1'b0;
        end
        if (issue_valid && (issue_rd != '0)) begin
            busy_next[issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write  <= 1'b0;
            rd         <= '0;
            write_data <= '0;
            busy       <= '0;
        end else begin
            reg_write <= sel_write;
            busy      <= busy_next;
            if (sel_write) begin
                rd         <= sel_req.rd;
                write_data <= sel_req.data;
            end
        end
    end

`ifdef WB_BYPASS_EN
    assign fwd_valid = sel_write;
    assign fwd_rd    = sel_req.rd;
    assign fwd_data  = sel_req.data;
`endif

    wb_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .push_data(mdu_req),
        .pop      (fifo_pop),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed scoreboard bench for wb_arbiter.
// Expected writes are queued by stimulus and checked by a monitor.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mdu_valid;
    logic        mdu_ready;
    logic [4:0]  mdu_rd;
    logic [31:0] mdu_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [31:0] busy;
    logic        reg_write;
    logic [4:0]  rd;
    logic [31:0] write_data;
`ifdef WB_BYPASS_EN
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
`endif

    wb_arbiter #(.FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .mdu_valid  (mdu_valid),
        .mdu_ready  (mdu_ready),
        .mdu_rd     (mdu_rd),
        .mdu_data   (mdu_data),
        .issue_valid(issue_valid),
        .issue_rd   (issue_rd),
        .busy       (busy),
        .reg_write  (reg_write),
        .rd         (rd),
        .write_data (write_data)
`ifdef WB_BYPASS_EN
        ,
        .fwd_valid  (fwd_valid),
        .fwd_rd     (fwd_rd),
        .fwd_data   (fwd_data)
`endif
    );

    always #5 clk = ~clk;

    int      n_vec = 0;
    int      n_err = 0;
    wb_req_t exp_q[$];
    wb_req_t mon_e;

    always @(negedge clk) begin
        if (reg_write) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL wb_unexpected: got rd=%0d data=%h, required no write",
                         rd, write_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (rd !== mon_e.rd || write_data !== mon_e.data) begin
                    n_err++;
                    $display("FAIL wb_order: got rd=%0d data=%h, required rd=%0d data=%h",
                             rd, write_data, mon_e.rd, mon_e.data);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic expect_wr(input logic [4:0] r, input logic [31:0] d);
        exp_q.push_back('{rd: r, data: d});
    endtask

    task automatic idle();
        alu_valid   = 1'b0;
        mdu_valid   = 1'b0;
        issue_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        alu_rd = '0; alu_data = '0;
        mdu_rd = '0; mdu_data = '0;
        issue_rd = '0;
        step();
        step();
        rst = 1'b0;
        check("rst_reg_write", 32'(reg_write), 32'd0);
        check("rst_rd", 32'(rd), 32'd0);
        check("rst_wdata", write_data, 32'd0);
        check("rst_busy", busy, 32'd0);
        check("rst_mdu_ready", 32'(mdu_ready), 32'd1);
        check("rst_alu_ready", 32'(alu_ready), 32'd1);

        // ALU only
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        expect_wr(5'd5, 32'hDEADBEEF);
        step();
        idle();
        check("alu_we", 32'(reg_write), 32'd1);
        check("alu_rd", 32'(rd), 32'd5);
        check("alu_data", write_data, 32'hDEADBEEF);
        step();

        // Collision, FIFO empty
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h1;
        mdu_valid = 1'b1; mdu_rd = 5'd4; mdu_data = 32'h2;
        expect_wr(5'd3, 32'h1);
        expect_wr(5'd4, 32'h2);
        step();
        idle();
        check("col_rd0", 32'(rd), 32'd3);
        step();
        check("col_we1", 32'(reg_write), 32'd1);
        check("col_rd1", 32'(rd), 32'd4);
        step();
        check("col_idle", 32'(reg_write), 32'd0);

        // Fill FIFO while ALU runs every cycle
        for (int i = 0; i < 4; i++) begin
            alu_valid = 1'b1;
            alu_rd = 5'(10 + i); alu_data = 32'hA0 + 32'(i);
            mdu_valid = 1'b1;
            mdu_rd = 5'(20 + i); mdu_data = 32'hC0 + 32'(i);
            expect_wr(5'(10 + i), 32'hA0 + 32'(i));
            step();
        end
        mdu_valid = 1'b0;
        alu_rd = 5'd14; alu_data = 32'hA4;
        expect_wr(5'd20, 32'hC0);
        expect_wr(5'd14, 32'hA4);
        expect_wr(5'd21, 32'hC1);
        expect_wr(5'd22, 32'hC2);
        expect_wr(5'd23, 32'hC3);
        check("full_mdu_ready", 32'(mdu_ready), 32'd0);
        check("full_alu_ready", 32'(alu_ready), 32'd0);
        step();
        check("full_head_rd", 32'(rd), 32'd20);
        check("full_alu_ready_back", 32'(alu_ready), 32'd1);
        step();
        check("full_alu_resume", 32'(rd), 32'd14);
        idle();
        repeat (4) step();
        check("full_drained", 32'(exp_q.size()), 32'd0);

        // Scoreboard
        issue_valid = 1'b1; issue_rd = 5'd7;
        step();
        idle();
        check("sb_set", busy, 32'h80);
        mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_data = 32'h70;
        expect_wr(5'd7, 32'h70);
        step();
        idle();
        check("sb_bypass_we", 32'(reg_write), 32'd1);
        check("sb_clear", busy, 32'h0);
        issue_valid = 1'b1; issue_rd = 5'd7;
        step();
        idle();
        mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_data = 32'h71;
        issue_valid = 1'b1; issue_rd = 5'd7;
        expect_wr(5'd7, 32'h71);
        step();
        idle();
        check("sb_set_wins_we", 32'(reg_write), 32'd1);
        check("sb_set_wins", busy, 32'h80);
        mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_data = 32'h7C;
        expect_wr(5'd7, 32'h7C);
        step();
        idle();
        check("sb_clear2", busy, 32'h0);

        // Register x0
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h55;
        step();
        idle();
        check("x0_we", 32'(reg_write), 32'd0);
        check("x0_rd_hold", 32'(rd), 32'd7);
        check("x0_data_hold", write_data, 32'h7C);
        issue_valid = 1'b1; issue_rd = 5'd0;
        step();
        idle();
        check("x0_busy", busy, 32'h0);

        // Reset with buffered results
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1'b1;
            alu_rd = 5'(11 + i); alu_data = 32'hA100 + 32'(i);
            mdu_valid = 1'b1;
            mdu_rd = 5'(21 + i); mdu_data = 32'hB100 + 32'(i);
            issue_valid = (i == 0);
            issue_rd = 5'd9;
            expect_wr(5'(11 + i), 32'hA100 + 32'(i));
            step();
        end
        idle();
        check("pre_rst_busy", busy, 32'h200);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_busy", busy, 32'h0);
        check("mid_rst_mdu_ready", 32'(mdu_ready), 32'd1);
        check("mid_rst_we", 32'(reg_write), 32'd0);
        repeat (4) step();
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4 (power of two, >=2), depth of the multiply/divide result buffer.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 alu_valid  input  1  single-cycle ALU result present.
REQ-005 alu_ready  output  1  ALU result accepted this cycle.
REQ-006 alu_rd  input  5  ALU destination register.
REQ-007 alu_data  input  32  ALU result.
REQ-008 mdu_valid  input  1  MUL/DIV result offered.
REQ-009 mdu_ready  output  1  MUL/DIV result buffer can accept.
REQ-010 mdu_rd  input  5  MUL/DIV destination register.
REQ-011 mdu_data  input  32  MUL/DIV result.
REQ-012 issue_valid  input  1  MUL/DIV op issued this cycle.
REQ-013 issue_rd  input  5  destination of the issued op.
REQ-014 busy  output  32  scoreboard; bit n = register n awaits a MUL/DIV result.
REQ-015 reg_write  output  1  register-file write enable.
REQ-016 rd  output  5  register-file write address.
REQ-017 write_data  output  32  register-file write data.

Function
REQ-018 reg_write, rd and write_data SHALL be registered; one write at most per cycle; latency input-accept -> write = 1 cycle (ALU) or >=1 cycle (MDU, via FIFO).
REQ-019 mdu_ready SHALL equal !fifo_full; an MDU result enters the FIFO when mdu_valid && mdu_ready.
REQ-020 Write selection per cycle: FIFO full -> FIFO head; else alu_valid -> ALU; else FIFO non-empty -> FIFO head; else no write.
REQ-021 alu_ready SHALL equal !fifo_full (combinational); when low the ALU holds its result.
REQ-022 When the FIFO is empty and mdu_valid with no alu_valid, the MDU result SHALL bypass the FIFO and be written the next cycle (no extra latency).
REQ-023 Simultaneous FIFO push and pop SHALL be legal at any occupancy except full (push blocked by REQ-019); pointers wrap modulo FIFO_DEPTH.
REQ-024 A selected entry with destination 0 SHALL be consumed but reg_write SHALL stay 0 and rd/write_data hold previous values.
REQ-025 Scoreboard: issue_valid with issue_rd!=0 sets busy[issue_rd]; an MDU write reaching reg_write clears busy[rd].
REQ-026 Same-cycle set and clear of the same bit: set SHALL win.
REQ-027 Ordering of MDU results SHALL be preserved (FIFO order); ALU results never reorder against each other.
REQ-028 WAW between an ALU write and a pending MDU write to the same register is excluded by upstream stall on busy; the block does not check it.

Reset
REQ-029 On rst: FIFO empty, busy=0, reg_write=0, rd=0, write_data=0; mdu_ready=1 and alu_ready=1 in the first cycle after reset.
REQ-030 rst mid-operation SHALL discard buffered results and pending busy bits without issuing any write.

Configuration
REQ-031 Macro WB_BYPASS_EN: when defined, outputs fwd_valid(1), fwd_rd(5), fwd_data(32) SHALL present the write selected this cycle (combinational, pre-register, fwd_valid=0 for rd 0); when undefined these ports and logic are absent and behaviour is otherwise identical.

Structure
REQ-032 Shared package holds XLEN=32, REG_ADDR_W=5, NUM_REGS=32 and a wb_req_t struct {rd, data}.
REQ-033 Sub-module wb_fifo (parameterised depth, wb_req_t entries, push/pop/full/empty) SHALL implement the buffer.

Verification
REQ-034 ALU only: alu_valid, rd=5, data=0xDEADBEEF -> next cycle reg_write=1, rd=5, write_data=0xDEADBEEF.
REQ-035 Collision: alu (rd=3, 0x1) and mdu (rd=4, 0x2) same cycle, FIFO empty -> writes rd=3 then rd=4 on consecutive cycles.
REQ-036 Full: hold alu_valid every cycle, push 4 MDU results -> mdu_ready=0, alu_ready=0, FIFO head written, then ALU resumes; no result lost.
REQ-037 Scoreboard: issue rd=7 -> busy[7]=1; MDU result rd=7 written -> busy[7]=0 same edge as reg_write; re-issue rd=7 on clear cycle -> busy[7] stays 1.
REQ-038 x0: ALU rd=0, data=0x55 -> reg_write stays 0; issue rd=0 -> busy unchanged.
REQ-039 Reset with 3 buffered MDU results -> no further writes, busy=0, mdu_ready=1.
